// File: rtl/cond_pkg.sv
// Shared condition-code encoding and NZCV flag bit positions.
// The flag indices are common to the ALU flag detector and the condition evaluator.
package cond_pkg;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    typedef enum logic [3:0] {
        CondEq = 4'd0,
        CondNe = 4'd1,
        CondCs = 4'd2,
        CondCc = 4'd3,
        CondMi = 4'd4,
        CondPl = 4'd5,
        CondVs = 4'd6,
        CondVc = 4'd7,
        CondHi = 4'd8,
        CondLs = 4'd9,
        CondGe = 4'd10,
        CondLt = 4'd11,
        CondGt = 4'd12,
        CondLe = 4'd13,
        CondAl = 4'd14,
        CondNv = 4'd15
    } cond_e;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

endpackage

// File: rtl/cond_logic.sv
// Combinational evaluation of a 4-bit condition code against a set of NZCV flags.
module cond_logic
    import cond_pkg::*;
(
    input  logic [3:0] flags,
    input  cond_e      cond,
    output logic       taken
);

    logic z, c, v, n;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CondEq: taken = z;
            CondNe: taken = !z;
            CondCs: taken = c;
            CondCc: taken = !c;
            CondMi: taken = n;
            CondPl: taken = !n;
            CondVs: taken = v;
            CondVc: taken = !v;
            CondHi: taken = c && !z;
            CondLs: taken = !c || z;
            CondGe: taken = (n == v);
            CondLt: taken = (n != v);
            CondGt: taken = !z && (n == v);
            CondLe: taken = z || (n != v);
            CondAl: taken = 1'b1;
            CondNv: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_evaluator.sv
// NZCV flag register with same-cycle forwarding, condition evaluation, a one-deep
// valid/ready response stage and a saturating count of taken conditions.
module cond_evaluator
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       flags_in,
    input  logic             flags_we,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [3:0]       resp_cond,
    input  logic             resp_ready,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_count
);

    state_e           state_q, state_d;
    logic [3:0]       flags_d;
    logic             resp_taken_q, resp_taken_d;
    logic [3:0]       resp_cond_q, resp_cond_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;
    logic [3:0]       eff_flags;
    logic             eval_taken;
    logic             accept;

    // A write in the same cycle as a query is forwarded so the query sees the new flags.
    assign eff_flags = flags_we ? flags_in : flags_q;

    cond_logic u_cond_logic (
        .flags (eff_flags),
        .cond  (cond_e'(req_cond)),
        .taken (eval_taken)
    );

    always_comb begin
        state_d       = state_q;
        resp_taken_d  = resp_taken_q;
        resp_cond_d   = resp_cond_q;
        taken_count_d = taken_count_q;
        flags_d       = flags_we ? flags_in : flags_q;
        req_ready     = (state_q == StEmpty) || resp_ready;
        accept        = req_valid && req_ready;

        if (accept) begin
            state_d      = StFull;
            resp_taken_d = eval_taken;
            resp_cond_d  = req_cond;
            if (eval_taken && (taken_count_q != {CNT_W{1'b1}})) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end else if ((state_q == StFull) && resp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StEmpty;
            flags_q       <= 4'b0000;
            resp_taken_q  <= 1'b0;
            resp_cond_q   <= 4'h0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            resp_taken_q  <= resp_taken_d;
            resp_cond_q   <= resp_cond_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign resp_valid  = (state_q == StFull);
    assign resp_taken  = resp_taken_q;
    assign resp_cond   = resp_cond_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_cond_evaluator.sv
// Scoreboard bench for cond_evaluator: stimulus pushes expected responses, a negedge
// monitor pops and compares each transferred response; a CNT_W=3 copy covers saturation.
module tb_cond_evaluator;

    typedef struct packed {
        logic       taken;
        logic [3:0] cond;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic        req_valid;
    logic [3:0]  req_cond;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_taken;
    logic [3:0]  resp_cond;
    logic        resp_ready;
    logic [3:0]  flags_q;
    logic [15:0] taken_count;

    logic        s_rst;
    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_resp_valid;
    logic        s_resp_taken;
    logic [3:0]  s_resp_cond;
    logic [3:0]  s_flags_q;
    logic [2:0]  s_taken_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    int          pop_cyc[$];
    exp_t        mon_e;
    logic [15:0] tb_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cond_evaluator #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flags_in    (flags_in),
        .flags_we    (flags_we),
        .req_valid   (req_valid),
        .req_cond    (req_cond),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_taken  (resp_taken),
        .resp_cond   (resp_cond),
        .resp_ready  (resp_ready),
        .flags_q     (flags_q),
        .taken_count (taken_count)
    );

    cond_evaluator #(.CNT_W(3)) dut_s (
        .clk         (clk),
        .rst         (s_rst),
        .flags_in    (4'h0),
        .flags_we    (1'b0),
        .req_valid   (s_req_valid),
        .req_cond    (4'd14),
        .req_ready   (s_req_ready),
        .resp_valid  (s_resp_valid),
        .resp_taken  (s_resp_taken),
        .resp_cond   (s_resp_cond),
        .resp_ready  (1'b1),
        .flags_q     (s_flags_q),
        .taken_count (s_taken_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] cond, input logic exp, input logic we,
                        input logic [3:0] fin);
        exp_t e;
        req_valid = 1'b1;
        req_cond  = cond;
        flags_we  = we;
        flags_in  = fin;
        e.taken   = exp;
        e.cond    = cond;
        sb.push_back(e);
        if (exp && tb_cnt != 16'hFFFF) tb_cnt = tb_cnt + 16'd1;
        step();
        req_valid = 1'b0;
        flags_we  = 1'b0;
    endtask

    task automatic write_flags(input logic [3:0] fin);
        flags_we = 1'b1;
        flags_in = fin;
        step();
        flags_we = 1'b0;
    endtask

    // Monitor: a response transfers at the next edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_taken", {31'd0, resp_taken}, {31'd0, mon_e.taken});
                check("resp_cond", {28'd0, resp_cond}, {28'd0, mon_e.cond});
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [15:0] cnt_before;
        tb_cnt      = 16'd0;
        rst         = 1'b1;
        flags_we    = 1'b1;
        flags_in    = 4'hF;
        req_valid   = 1'b0;
        req_cond    = 4'h0;
        resp_ready  = 1'b1;
        s_rst       = 1'b1;
        s_req_valid = 1'b0;

        // Reset dominates a simultaneous flag write.
        step();
        step();
        check("rst_flags_q", {28'd0, flags_q}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_taken_count", {16'd0, taken_count}, 32'd0);
        rst      = 1'b0;
        flags_we = 1'b0;
        flags_in = 4'h0;
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Forwarding: EQ issued together with the write of Z.
        send(4'd0, 1'b1, 1'b1, 4'b0001);
        check("fwd_flags_q", {28'd0, flags_q}, 32'h1);

        // N=1 V=1 Z=0 C=0
        write_flags(4'b1100);
        send(4'd10, 1'b1, 1'b0, 4'h0);
        send(4'd11, 1'b0, 1'b0, 4'h0);
        send(4'd12, 1'b1, 1'b0, 4'h0);
        send(4'd13, 1'b0, 1'b0, 4'h0);
        send(4'd4,  1'b1, 1'b0, 4'h0);
        send(4'd2,  1'b0, 1'b0, 4'h0);
        send(4'd8,  1'b0, 1'b0, 4'h0);
        send(4'd9,  1'b1, 1'b0, 4'h0);
        // N=1 V=0 Z=0 C=0
        write_flags(4'b1000);
        send(4'd10, 1'b0, 1'b0, 4'h0);
        send(4'd11, 1'b1, 1'b0, 4'h0);
        send(4'd12, 1'b0, 1'b0, 4'h0);
        send(4'd13, 1'b1, 1'b0, 4'h0);
        step();
        check("count_after_signed", {16'd0, taken_count}, {16'd0, tb_cnt});

        // Backpressure: AL held for 5 cycles, flag write in the middle.
        resp_ready = 1'b0;
        send(4'd14, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_resp_taken", {31'd0, resp_taken}, 32'd1);
            check("stall_resp_cond", {28'd0, resp_cond}, 32'd14);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            if (i == 2) begin
                flags_we = 1'b1;
                flags_in = 4'b0001;
            end
            step();
            flags_we = 1'b0;
        end
        check("stall_flag_write", {28'd0, flags_q}, 32'h1);
        resp_ready = 1'b1;
        send(4'd15, 1'b0, 1'b0, 4'h0);
        step();

        // Held flag-dependent response must not follow a later flag write (Z=1 now).
        resp_ready = 1'b0;
        send(4'd0, 1'b1, 1'b0, 4'h0);
        write_flags(4'b0000);
        check("frozen_resp_taken", {31'd0, resp_taken}, 32'd1);
        step();
        check("frozen_resp_taken2", {31'd0, resp_taken}, 32'd1);
        resp_ready = 1'b1;
        step();
        step();

        // Streaming: 8 back-to-back AL/NV queries.
        base       = pop_cyc.size();
        cnt_before = tb_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(4'd14, 1'b1, 1'b0, 4'h0);
            else            send(4'd15, 1'b0, 1'b0, 4'h0);
        end
        step();
        step();
        check("stream_resp_count", pop_cyc.size() - base, 32'd8);
        if (pop_cyc.size() - base == 8) begin
            check("stream_consecutive", pop_cyc[base+7] - pop_cyc[base], 32'd7);
        end
        check("stream_taken_count", {16'd0, taken_count}, {16'd0, cnt_before + 16'd4});

        // Saturation on the CNT_W=3 instance, then reset mid-stream.
        s_rst       = 1'b0;
        s_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sat_taken_count", {29'd0, s_taken_count}, (i + 1 > 7) ? 32'd7 : i + 1);
        end
        s_rst = 1'b1;
        step();
        check("sat_rst_resp_valid", {31'd0, s_resp_valid}, 32'd0);
        check("sat_rst_taken_count", {29'd0, s_taken_count}, 32'd0);
        s_rst       = 1'b0;
        s_req_valid = 1'b0;

        step();
        step();
        check("sb_drained", sb.size(), 32'd0);
        check("final_taken_count", {16'd0, taken_count}, {16'd0, tb_cnt});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
